axis_dac_arbiter: RTL and testbench
===================================

AXIS_DAC_ARBITER -- requirements
Module: axis_dac_arbiter

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32: width of every stream tdata (two 16-bit DAC lanes).
REQ-002 Parameter CFG_DATA_WIDTH, default 32: configuration word width.
REQ-003 Parameter CNTR_WIDTH, default 16: burst and beat counter width.
REQ-004 Port aclk, input, 1: single clock for all logic.
REQ-005 Port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port cfg_data, input, CFG_DATA_WIDTH: [15:0] burst length in beats (0 = unlimited), [23:16] guard cycles, [24] fixed priority to s00.
REQ-007 Port sts_data, output, 32: [0] s00 granted, [1] s01 granted, [2] guard active, [31:16] beats accepted in current/last burst.
REQ-008 Ports s00_axis_tdata/tvalid (input) and s00_axis_tready (output): requester 0 stream.
REQ-009 Ports s01_axis_tdata/tvalid (input) and s01_axis_tready (output): requester 1 stream.
REQ-010 Ports m_axis_tdata/tvalid (output) and m_axis_tready (input): stream toward the DAC output stage.

Function
REQ-011 The block SHALL implement states IDLE, GRANT0, GRANT1 and GUARD.
REQ-012 IDLE: s00 valid only -> GRANT0; s01 valid only -> GRANT1; both valid -> GRANT0 if cfg bit 24 set, else the requester not granted last (round robin); neither -> stay.
REQ-013 On IDLE->GRANTn the block SHALL latch burst length and guard count from cfg_data; cfg changes have no effect until the next grant.
REQ-014 Output register SHALL load when m_axis_tvalid is low or m_axis_tready is high ("load enable"); latency from accepted input beat to m_axis_tvalid is exactly 1 cycle.
REQ-015 sNN_axis_tready SHALL equal load enable while in GRANTnn and 0 otherwise; the non-granted requester always sees tready 0.
REQ-016 Beat accepted = granted tvalid and tready high; each accepted beat SHALL copy tdata to m_axis_tdata, set m_axis_tvalid, and increment the beat counter.
REQ-017 When load enable is high and no beat is accepted, m_axis_tvalid SHALL go low and m_axis_tdata SHALL hold its value.
REQ-018 Burst SHALL end on the accept of beat number burst length (nonzero length), or on the first cycle in GRANTn with load enable high and granted tvalid low.
REQ-019 At burst end: guard count > 0 -> GUARD, else -> IDLE; last-granted pointer updated to n.
REQ-020 GUARD SHALL keep both treadys 0 for exactly guard-count cycles, then enter IDLE; requester tvalid during GUARD is ignored.
REQ-021 Beat counter SHALL clear on IDLE->GRANTn, saturate at all-ones, and report in sts_data[31:16] until the next grant.
REQ-022 Unlimited burst (length 0) SHALL persist until the granted tvalid drops (REQ-018), with no beat limit.
REQ-023 m_axis_tready held low SHALL stall the grant without ending the burst or advancing the counter.

Reset
REQ-024 aresetn low SHALL immediately force state IDLE, last-granted = s01 (s00 wins first contention), m_axis_tvalid 0, m_axis_tdata 0, both treadys 0, counters 0, sts_data 0.
REQ-025 Reset mid-burst SHALL discard the burst; after release the first cycle is IDLE with no stale beat output.

Structure
REQ-026 State encodings and cfg field offsets/widths SHALL live in the shared package, for reuse by the DAC software-side register map.
REQ-027 Single flat module; no sub-module is needed (round-robin pick and counters are inline).

Verification
REQ-028 Both valid, cfg=0x0002_0004 (len 4, guard 2, RR) -> s00 4 beats, tready low 2 cycles, s01 4 beats, then s00 again.
REQ-029 cfg bit 24 set, both continuously valid, len 3 guard 0 -> only s00 ever granted, 3-beat bursts back to back via IDLE.
REQ-030 len 0, s01 sends 10 beats then drops tvalid -> burst ends, sts_data[31:16]=10, m_axis_tvalid low 1 cycle after last beat.
REQ-031 m_axis_tready low 5 cycles mid-burst -> m_axis_tdata held, no beat lost or duplicated, counter frozen.
REQ-032 aresetn asserted during beat 3 of an 8-beat burst -> all outputs 0 asynchronously; after release both contend and s00 granted first.

Source files
------------

// File: rtl/axis_dac_arbiter_pkg.sv
// Shared encodings for the DAC stream arbiter: FSM state codes and cfg_data field layout.
// The software-side register map reuses these to stay consistent with the hardware.
package axis_dac_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_GUARD  = 2'd3;

    localparam int CFG_LEN_LSB   = 0;
    localparam int CFG_LEN_W     = 16;
    localparam int CFG_GUARD_LSB = 16;
    localparam int CFG_GUARD_W   = 8;
    localparam int CFG_PRIO_BIT  = 24;
    localparam int CFG_USED_W    = CFG_PRIO_BIT + 1;

    typedef logic [CFG_USED_W-1:0] cfg_used_t;

    function automatic logic [CFG_LEN_W-1:0] cfg_burst_len(input cfg_used_t cfg);
        return cfg[CFG_LEN_LSB +: CFG_LEN_W];
    endfunction

    function automatic logic [CFG_GUARD_W-1:0] cfg_guard_len(input cfg_used_t cfg);
        return cfg[CFG_GUARD_LSB +: CFG_GUARD_W];
    endfunction

endpackage

// File: rtl/axis_dac_arbiter.sv
// Two-requester AXI-Stream arbiter feeding a DAC output register, with burst limit,
// round-robin or fixed priority, and a post-burst guard gap.
//
// state  | meaning
// IDLE   | no owner; pick a requester from the live tvalids
// GRANT0 | s00 owns the output register until its burst ends
// GRANT1 | s01 owns the output register until its burst ends
// GUARD  | both treadys low for the latched guard count
module axis_dac_arbiter
    import axis_dac_arbiter_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CFG_DATA_WIDTH   = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CFG_DATA_WIDTH-1:0]   cfg_data,
    output logic [31:0]                 sts_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                        s00_axis_tvalid,
    output logic                        s00_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                        s01_axis_tvalid,
    output logic                        s01_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    logic [1:0]                  r_state;
    logic                        r_last_s01;
    logic [CNTR_WIDTH-1:0]       r_burst_len;
    logic [CNTR_WIDTH-1:0]       r_beat_cnt;
    logic [CFG_GUARD_W-1:0]      r_guard_len;
    logic [CFG_GUARD_W-1:0]      r_guard_cnt;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                        r_tvalid;

    logic                        w_load_en;
    logic                        w_gnt0;
    logic                        w_gnt1;
    logic                        w_sel_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] w_sel_tdata;
    logic                        w_accept;
    logic                        w_last_beat;
    logic                        w_burst_end;
    logic                        w_pick_s01;
    logic                        w_prio_s00;
    cfg_used_t                   w_cfg;
    logic                        w_cfg_unused;

    assign w_cfg        = cfg_data[CFG_USED_W-1:0];
    assign w_cfg_unused = ^cfg_data[CFG_DATA_WIDTH-1:CFG_USED_W];
    assign w_prio_s00   = w_cfg[CFG_PRIO_BIT];

    assign w_load_en    = !r_tvalid || m_axis_tready;
    assign w_gnt0       = (r_state == ST_GRANT0);
    assign w_gnt1       = (r_state == ST_GRANT1);
    assign w_sel_tvalid = w_gnt1 ? s01_axis_tvalid : s00_axis_tvalid;
    assign w_sel_tdata  = w_gnt1 ? s01_axis_tdata  : s00_axis_tdata;
    assign w_accept     = (w_gnt0 || w_gnt1) && w_load_en && w_sel_tvalid;
    assign w_last_beat  = (r_burst_len != '0) && (r_beat_cnt == r_burst_len - CNT_ONE);
    assign w_burst_end  = (w_gnt0 || w_gnt1) && w_load_en && (!w_sel_tvalid || w_last_beat);

    // Contention goes to s01 only when s00 was the last owner and priority is not fixed.
    assign w_pick_s01   = s01_axis_tvalid && (!s00_axis_tvalid || (!w_prio_s00 && !r_last_s01));

    assign s00_axis_tready = w_gnt0 && w_load_en;
    assign s01_axis_tready = w_gnt1 && w_load_en;
    assign m_axis_tdata    = r_tdata;
    assign m_axis_tvalid   = r_tvalid;
    assign sts_data        = {16'(r_beat_cnt), 13'd0, (r_state == ST_GUARD), w_gnt1, w_gnt0};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_last_s01  <= 1'b1;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
            r_guard_len <= '0;
            r_guard_cnt <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tdata  <= w_sel_tdata;
                r_tvalid <= 1'b1;
            end else if (w_load_en) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (s00_axis_tvalid || s01_axis_tvalid) begin
                        r_state     <= w_pick_s01 ? ST_GRANT1 : ST_GRANT0;
                        r_burst_len <= CNTR_WIDTH'(cfg_burst_len(w_cfg));
                        r_guard_len <= cfg_guard_len(w_cfg);
                        r_beat_cnt  <= '0;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (w_accept && (r_beat_cnt != '1)) begin
                        r_beat_cnt <= r_beat_cnt + CNT_ONE;
                    end
                    if (w_burst_end) begin
                        r_last_s01 <= w_gnt1;
                        if (r_guard_len != '0) begin
                            r_state     <= ST_GUARD;
                            r_guard_cnt <= r_guard_len;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_guard_cnt <= r_guard_cnt - CFG_GUARD_W'(1);
                    if (r_guard_cnt <= CFG_GUARD_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_dac_arbiter.sv
// Bench for axis_dac_arbiter: cycle-level behavioural model checked every cycle under
// random traffic, plus directed scenarios with hand-computed expectations.
module tb_axis_dac_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [31:0] cfg_data;
    logic [31:0] sts_data;
    logic [31:0] s00_axis_tdata;
    logic        s00_axis_tvalid;
    logic        s00_axis_tready;
    logic [31:0] s01_axis_tdata;
    logic        s01_axis_tvalid;
    logic        s01_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    int n_vec = 0;
    int n_err = 0;

    // model state: who owns the output (-1 none), guard cycles still to go, beats this burst
    bit          mdl_tvalid;
    logic [31:0] mdl_tdata;
    int          mdl_owner;
    int          mdl_guard_left;
    int          mdl_last;
    int          mdl_beats;
    int          mdl_len;
    int          mdl_guard;

    int          acc_src[$];
    logic [31:0] out_q[$];
    int          guard_seen;

    axis_dac_arbiter dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cfg_data        (cfg_data),
        .sts_data        (sts_data),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tready (s00_axis_tready),
        .s01_axis_tdata  (s01_axis_tdata),
        .s01_axis_tvalid (s01_axis_tvalid),
        .s01_axis_tready (s01_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_tvalid     = 1'b0;
        mdl_tdata      = '0;
        mdl_owner      = -1;
        mdl_guard_left = 0;
        mdl_last       = 1;
        mdl_beats      = 0;
        mdl_len        = 0;
        mdl_guard      = 0;
    endtask

    task automatic check_and_model();
        bit          ready_ok;
        bit          v;
        bit          end_b;
        logic [31:0] exp_sts;
        if (!aresetn) mdl_reset();
        ready_ok = !mdl_tvalid || m_axis_tready;
        exp_sts  = {16'(mdl_beats), 13'd0, (mdl_guard_left > 0), (mdl_owner == 1), (mdl_owner == 0)};
        chk("s00_tready", 64'(s00_axis_tready), 64'((mdl_owner == 0) && ready_ok));
        chk("s01_tready", 64'(s01_axis_tready), 64'((mdl_owner == 1) && ready_ok));
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(mdl_tvalid));
        chk("m_tdata", 64'(m_axis_tdata), 64'(mdl_tdata));
        chk("sts_data", 64'(sts_data), 64'(exp_sts));

        if (s00_axis_tready && s00_axis_tvalid) acc_src.push_back(0);
        if (s01_axis_tready && s01_axis_tvalid) acc_src.push_back(1);
        if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
        if (sts_data[2]) guard_seen++;
        if (!aresetn) return;

        if (mdl_owner >= 0) begin
            v     = (mdl_owner == 0) ? s00_axis_tvalid : s01_axis_tvalid;
            end_b = 1'b0;
            if (ready_ok && v) begin
                mdl_tdata  = (mdl_owner == 0) ? s00_axis_tdata : s01_axis_tdata;
                mdl_tvalid = 1'b1;
                if (mdl_beats < 65535) mdl_beats++;
                if (mdl_len != 0 && mdl_beats == mdl_len) end_b = 1'b1;
            end else if (ready_ok) begin
                mdl_tvalid = 1'b0;
                end_b      = 1'b1;
            end
            if (end_b) begin
                mdl_last       = mdl_owner;
                mdl_guard_left = mdl_guard;
                mdl_owner      = -1;
            end
        end else begin
            if (ready_ok) mdl_tvalid = 1'b0;
            if (mdl_guard_left > 0) begin
                mdl_guard_left--;
            end else if (s00_axis_tvalid || s01_axis_tvalid) begin
                if (s00_axis_tvalid && s01_axis_tvalid)
                    mdl_owner = cfg_data[24] ? 0 : 1 - mdl_last;
                else
                    mdl_owner = s00_axis_tvalid ? 0 : 1;
                mdl_beats = 0;
                mdl_len   = int'(cfg_data[15:0]);
                mdl_guard = int'(cfg_data[23:16]);
            end
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        check_and_model();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn         = 1'b0;
        s00_axis_tvalid = 1'b0;
        s01_axis_tvalid = 1'b0;
        m_axis_tready   = 1'b1;
        tick();
        tick();
        aresetn = 1'b1;
        acc_src.delete();
        out_q.delete();
        guard_seen = 0;
    endtask

    task automatic scen_round_robin();
        int n;
        int exp_src[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        cfg_data = 32'h0002_0004;
        do_reset();
        s00_axis_tvalid = 1'b1;
        s01_axis_tvalid = 1'b1;
        s00_axis_tdata  = 32'hA000_0000;
        s01_axis_tdata  = 32'hB000_0000;
        for (n = 0; n < 80 && acc_src.size() < 12; n++) tick();
        chk("rr_cycles", 64'(n), 64'd19);
        for (int i = 0; i < 12; i++)
            chk("rr_order", 64'((i < acc_src.size()) ? acc_src[i] : 9), 64'(exp_src[i]));
        chk("rr_guard_cycles", 64'(guard_seen), 64'd4);
    endtask

    task automatic scen_fixed_prio();
        int n;
        int n_s01;
        cfg_data = 32'h0100_0003;
        do_reset();
        s00_axis_tvalid = 1'b1;
        s01_axis_tvalid = 1'b1;
        for (n = 0; n < 60 && acc_src.size() < 9; n++) tick();
        n_s01 = 0;
        foreach (acc_src[i]) if (acc_src[i] != 0) n_s01++;
        chk("prio_cycles", 64'(n), 64'd12);
        chk("prio_s01_beats", 64'(n_s01), 64'd0);
        chk("prio_guard", 64'(guard_seen), 64'd0);
    endtask

    task automatic scen_unlimited();
        int k;
        cfg_data = 32'h0000_0000;
        do_reset();
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            s01_axis_tvalid = 1'b1;
            s01_axis_tdata  = 32'h0000_0B00 + 32'(k);
            tick();
            k = acc_src.size();
        end
        chk("unl_beats_sent", 64'(k), 64'd10);
        s01_axis_tvalid = 1'b0;
        chk("unl_last_valid", 64'(m_axis_tvalid), 64'd1);
        chk("unl_last_data", 64'(m_axis_tdata), 64'h0B09);
        tick();
        chk("unl_valid_low", 64'(m_axis_tvalid), 64'd0);
        chk("unl_sts_beats", 64'(sts_data[31:16]), 64'd10);
        chk("unl_sts_gnt", 64'(sts_data[2:0]), 64'd0);
    endtask

    task automatic scen_stall();
        int k;
        cfg_data = 32'h0000_0008;
        do_reset();
        k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            s00_axis_tvalid = 1'b1;
            s00_axis_tdata  = 32'h0000_0A00 + 32'(k);
            tick();
            k = acc_src.size();
        end
        m_axis_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            s00_axis_tdata = 32'h0000_0A00 + 32'(k);
            tick();
            chk("stall_hold_data", 64'(m_axis_tdata), 64'h0A02);
            chk("stall_hold_cnt", 64'(sts_data[31:16]), 64'd3);
        end
        m_axis_tready = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            s00_axis_tdata = 32'h0000_0A00 + 32'(k);
            tick();
            k = acc_src.size();
        end
        s00_axis_tvalid = 1'b0;
        tick();
        tick();
        chk("stall_out_count", 64'(out_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk("stall_out_data", 64'((i < out_q.size()) ? out_q[i] : 32'hFFFF_FFFF), 64'(32'h0A00 + 32'(i)));
        chk("stall_sts_beats", 64'(sts_data[31:16]), 64'd8);
    endtask

    task automatic scen_reset_mid();
        int n;
        cfg_data = 32'h0000_0008;
        do_reset();
        s00_axis_tvalid = 1'b1;
        s01_axis_tvalid = 1'b1;
        s00_axis_tdata  = 32'h1234_5678;
        s01_axis_tdata  = 32'h8765_4321;
        for (n = 0; n < 20 && acc_src.size() < 2; n++) tick();
        chk("rst_pre_beats", 64'(acc_src.size()), 64'd2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_treadys", 64'({s00_axis_tready, s01_axis_tready}), 64'd0);
        chk("rst_sts", 64'(sts_data), 64'd0);
        tick();
        aresetn = 1'b1;
        acc_src.delete();
        chk("rst_no_stale", 64'(m_axis_tvalid), 64'd0);
        for (n = 0; n < 20 && acc_src.size() < 1; n++) tick();
        chk("rst_first_grant", 64'((acc_src.size() > 0) ? acc_src[0] : 9), 64'd0);
    endtask

    task automatic run_random(input int ncyc);
        int p_v0;
        int p_v1;
        int p_rdy;
        p_v0 = 80;
        p_v1 = 80;
        p_rdy = 80;
        for (int i = 0; i < ncyc; i++) begin
            if (i % 250 == 0) begin
                p_v0  = $urandom_range(10, 100);
                p_v1  = $urandom_range(10, 100);
                p_rdy = $urandom_range(20, 100);
            end
            s00_axis_tvalid = ($urandom_range(0, 99) < p_v0);
            s01_axis_tvalid = ($urandom_range(0, 99) < p_v1);
            s00_axis_tdata  = $urandom;
            s01_axis_tdata  = $urandom;
            m_axis_tready   = ($urandom_range(0, 99) < p_rdy);
            if ($urandom_range(0, 9) == 0)
                cfg_data = {7'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 16'($urandom_range(0, 6))};
            aresetn = ($urandom_range(0, 499) != 0);
            tick();
        end
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn         = 1'b0;
        cfg_data        = '0;
        s00_axis_tdata  = '0;
        s00_axis_tvalid = 1'b0;
        s01_axis_tdata  = '0;
        s01_axis_tvalid = 1'b0;
        m_axis_tready   = 1'b1;
        guard_seen      = 0;
        mdl_reset();
        @(posedge aclk);
        #1;
        tick();
        chk("reset_sts", 64'(sts_data), 64'd0);
        chk("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);

        scen_round_robin();
        scen_fixed_prio();
        scen_unlimited();
        scen_stall();
        scen_reset_mid();

        do_reset();
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
